dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the pipeline's memory-access stage (cpu) and an external loader/debug port (ext).
- Decides the grant each cycle, drives the memory address, write-enable and write-data, and returns read data one cycle later to the requester that issued the read.
- Also provides an ext lock mode for bursts and blocks accesses whose address falls outside DMEM_SIZE.

---
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the cpu MEM stage and an ext loader/debug port
// Ports: CLK/RST (async active-low); cpu_*/ext_* request, grant, stall and read-return channels;
//   ext_lock holds ext ownership across a burst; mem_* drive the synchronous-read memory;
//   addr_err pulses the cycle after a granted out-of-range access.
// Optional: define DMEM_ARB_AGE_EN to let ext win a contested cycle after MAX_WAIT denied cycles.
module dmem_arbiter #(
  parameter int DMEM_SIZE = 1024,
  parameter int AW = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [31:0]   ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [31:0]   ext_rdata,
  input  logic          ext_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          addr_err
);
  localparam logic [0:0] ARB = 1'b0, LOCK = 1'b1;
  localparam logic [31:0] SIZE = DMEM_SIZE;
  logic [0:0] state;
  logic age_win, any_gnt, in_range, rd_oor;
  logic [31:0] sel_addr, rdata, cpu_hold, ext_hold;
`ifdef DMEM_ARB_AGE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MW = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) wait_cnt <= '0;
    else wait_cnt <= (ext_req & ~ext_gnt) ? (wait_cnt == MW ? wait_cnt : wait_cnt + CW'(1)) : '0;
  assign age_win = (state == ARB) & (wait_cnt == MW);
`else
  // strict cpu priority; the comparison is constant-false and only keeps MAX_WAIT referenced
  assign age_win = MAX_WAIT < 0;
`endif
  assign ext_gnt = ext_req & ((state == LOCK) | ~cpu_req | age_win);
  assign cpu_gnt = cpu_req & (state == ARB) & ~(ext_req & age_win);
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign any_gnt = cpu_gnt | ext_gnt;
  assign sel_addr = ext_gnt ? ext_addr : cpu_addr;
  assign in_range = {2'b00, sel_addr[31:2]} < SIZE;
  assign mem_en = any_gnt & in_range;
  assign mem_we = mem_en & (ext_gnt ? ext_we : cpu_we);
  assign mem_addr = any_gnt ? sel_addr[AW+1:2] : '0;
  assign mem_wdata = ext_gnt ? ext_wdata : (cpu_gnt ? cpu_wdata : '0);
  // an out-of-range load never reached the memory, so it returns zero instead of stale mem_rdata
  assign rdata = rd_oor ? '0 : mem_rdata;
  assign cpu_rdata = cpu_rvalid ? rdata : cpu_hold;
  assign ext_rdata = ext_rvalid ? rdata : ext_hold;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= ARB;
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
      rd_oor <= 1'b0;
      addr_err <= 1'b0;
      cpu_hold <= '0;
      ext_hold <= '0;
    end else begin
      state <= (state == ARB) ? ((ext_gnt & ext_lock) ? LOCK : ARB) : (ext_lock ? LOCK : ARB);
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ext_rvalid <= ext_gnt & ~ext_we;
      rd_oor <= ~in_range;
      addr_err <= any_gnt & ~in_range;
      if (cpu_rvalid) cpu_hold <= rdata;
      if (ext_rvalid) ext_hold <= rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a cycle-level reference model
module tb_dmem_arbiter;
  localparam int DS = 1024, AW = 10, MW = 2;
  logic CLK = 1'b0, RST = 1'b0;
  logic cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0, ext_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_we, addr_err;
  logic [31:0] cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_clr = 1'b1;
  logic [31:0] mem [0:DS-1];
  always #5 CLK = ~CLK;
  dmem_arbiter #(.DMEM_SIZE(DS), .AW(AW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_lock(ext_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err));
  always @(posedge CLK)
    if (mem_clr) for (int i = 0; i < DS; i++) mem[i] <= '0;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  typedef struct {
    bit cg, eg, stall, en, we, crv, erv, err;
    logic [AW-1:0] addr;
    logic [31:0] wdata, crd, erd;
  } rec_t;
  rec_t rec_q[$];
  logic [31:0] cpu_q[$], ext_q[$];
  int tests = 0, fails = 0;
  bit mon_en = 0;
  bit locked, p_crv, p_erv, p_err;
  int wcnt;
  logic [31:0] p_crd, p_erd, last_crd, last_erd;
  logic [31:0] ref_mem [0:DS-1];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask
  task automatic model_clear();
    locked = 0; wcnt = 0; p_crv = 0; p_erv = 0; p_err = 0;
    p_crd = 0; p_erd = 0; last_crd = 0; last_erd = 0;
  endtask
  task automatic check_reset_outputs();
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_ext_rvalid", 32'(ext_rvalid), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_ext_gnt", 32'(ext_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
  endtask
  // One clock of stimulus; the model derives everything the DUT must show this cycle
  task automatic step(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit er, input bit ew, input logic [31:0] ea, input logic [31:0] ed, input bit el);
    rec_t r;
    bit age, cg, eg, w, oor;
    logic [31:0] a, idx, d;
    @(posedge CLK);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed; ext_lock = el;
    age = 0;
`ifdef DMEM_ARB_AGE_EN
    age = !locked && wcnt == MW;
`endif
    eg = er && (locked || !cr || age);
    cg = cr && !locked && !eg;
    a = eg ? ea : ca;
    w = eg ? ew : cw;
    idx = a >> 2;
    oor = (cg || eg) && idx >= DS;
    r.cg = cg; r.eg = eg; r.stall = cr && !cg;
    r.en = (cg || eg) && !oor;
    r.we = r.en && w;
    r.addr = (cg || eg) ? idx[AW-1:0] : '0;
    r.wdata = eg ? ed : cd;
    r.crv = p_crv; r.erv = p_erv; r.err = p_err;
    r.crd = p_crv ? p_crd : last_crd; last_crd = r.crd;
    r.erd = p_erv ? p_erd : last_erd; last_erd = r.erd;
    d = oor ? 0 : ref_mem[idx[AW-1:0]];
    p_crv = cg && !w; p_erv = eg && !w; p_err = oor;
    if (p_crv) begin p_crd = d; cpu_q.push_back(d); end
    if (p_erv) begin p_erd = d; ext_q.push_back(d); end
    if (r.we) ref_mem[idx[AW-1:0]] = r.wdata;
    locked = locked ? el : (eg && el);
    wcnt = (er && !eg) ? (wcnt == MW ? MW : wcnt + 1) : 0;
    rec_q.push_back(r);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? 32'((DS + $urandom_range(0, 15)) * 4) : 32'($urandom_range(0, 31) * 4);
  endfunction
  always @(negedge CLK)
    if (mon_en && rec_q.size() > 0) begin
      rec_t r;
      r = rec_q.pop_front();
      chk("cpu_gnt", 32'(cpu_gnt), 32'(r.cg));
      chk("ext_gnt", 32'(ext_gnt), 32'(r.eg));
      chk("cpu_stall", 32'(cpu_stall), 32'(r.stall));
      chk("mem_en", 32'(mem_en), 32'(r.en));
      chk("mem_we", 32'(mem_we), 32'(r.we));
      chk("mem_addr", 32'(mem_addr), 32'(r.addr));
      if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
      chk("addr_err", 32'(addr_err), 32'(r.err));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(r.crv));
      chk("ext_rvalid", 32'(ext_rvalid), 32'(r.erv));
      chk("cpu_rdata_hold", cpu_rdata, r.crd);
      chk("ext_rdata_hold", ext_rdata, r.erd);
      if (cpu_rvalid || r.crv) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_return: rvalid with no cpu load outstanding");
        end else chk("cpu_return", cpu_rdata, cpu_q.pop_front());
      end
      if (ext_rvalid || r.erv) begin
        if (ext_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ext_return: rvalid with no ext load outstanding");
        end else chk("ext_return", ext_rdata, ext_q.pop_front());
      end
    end
  initial begin
    for (int i = 0; i < DS; i++) ref_mem[i] = '0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs();
    mem_clr = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    mon_en = 1;
    // reset while a cpu load is in flight: its return must be discarded
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    mon_en = 0;
    cpu_req = 0; cpu_we = 0; ext_req = 0; ext_we = 0; ext_lock = 0;
    model_clear();
    cpu_q.delete(); ext_q.delete(); rec_q.delete();
    @(posedge CLK);
    #1;
    check_reset_outputs();
    @(negedge CLK);
    RST = 1'b1;
    mon_en = 1;
    idle(2);
    // cpu store/load round trip
    step(1, 1, 32'h40, 32'h12345678, 0, 0, 0, 0, 0);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    idle(1);
    // contention: ext starves by default, wins on the third cycle when aging is enabled
    for (int i = 0; i < 3; i++) step(1, 0, 32'h40, 0, 1, 0, 32'h80, 0, 0);
    idle(2);
    // lock burst with the cpu waiting
    step(0, 0, 0, 0, 1, 1, 32'h0, 32'h11, 1);
    step(1, 0, 32'h40, 0, 1, 1, 32'h4, 32'h22, 1);
    step(1, 0, 32'h40, 0, 1, 1, 32'h8, 32'h33, 1);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 1);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    idle(1);
    // out-of-range store and load
    step(1, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 32'h1000, 0, 0, 0, 0, 0, 0);
    idle(2);
    // interleaved ext/cpu returns
    step(1, 1, 32'h20, 32'hA, 0, 0, 0, 0, 0);
    step(1, 1, 32'h24, 32'hB, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    step(1, 0, 32'h24, 0, 0, 0, 0, 0, 0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit er;
      er = $urandom_range(0, 99) < 50;
      step($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
           er, 1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
           er ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0));
    end
    idle(3);
    @(negedge CLK);
    #1;
    chk("rec_q_drained", 32'(rec_q.size()), 0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    chk("ext_q_drained", 32'(ext_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
